// File: rtl/mux_select_arbiter_pkg.sv
// Shared definitions for the 4:1 multiplexer select arbiter.
// Contents:
//   arb_state_e    - arbiter FSM state encoding (idle = 0, granted = 1)
//   MaxHoldDefault - default maximum grant length in cycles
//   HoldCntWidth   - width of the grant hold counter
//   NumSources     - number of requesters / multiplexer data inputs
//   onehot4()      - 2-bit index to 4-bit one-hot grant vector
package mux_select_arbiter_pkg;

    typedef enum logic {
        StIdle    = 1'b0,
        StGranted = 1'b1
    } arb_state_e;

    localparam int unsigned MaxHoldDefault = 8;
    localparam int unsigned HoldCntWidth   = 4;
    localparam int unsigned NumSources     = 4;

    typedef logic [HoldCntWidth-1:0] hold_cnt_t;

    function automatic logic [NumSources-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the four multiplexer sources and the arbiter.
// Signals:
//   req0..req3    - level requests from sources 0..3
//   owner_release - single-cycle pulse from the current owner ending its grant
//   address0/1    - multiplexer select LSB/MSB
//   grant         - one-hot grant, bit i = source i owns the multiplexer
//   grant_valid   - high while a grant is held
//   timeout       - single-cycle pulse on a forced release
// Modports:
//   master - the requester side (drives requests and release)
//   slave  - the arbiter side (drives select, grant and status)
interface mux_select_arbiter_if;

    logic       req0;
    logic       req1;
    logic       req2;
    logic       req3;
    logic       owner_release;
    logic       address0;
    logic       address1;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req0, req1, req2, req3, owner_release,
        input  address0, address1, grant, grant_valid, timeout
    );

    modport slave (
        input  req0, req1, req2, req3, owner_release,
        output address0, address1, grant, grant_valid, timeout
    );

endinterface

// File: rtl/mux_select_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
// Ports:
//   req        - 4-bit request vector
//   last_owner - index of the most recent owner; search starts one above it
//   idx        - index of the chosen requester (last_owner when none found)
//   found      - high when at least one request is present
module rr_priority_picker
    import mux_select_arbiter_pkg::*;
(
    input  logic [NumSources-1:0] req,
    input  logic [1:0]            last_owner,
    output logic [1:0]            idx,
    output logic                  found
);

    always_comb begin
        logic [1:0] cand;
        idx   = last_owner;
        found = 1'b0;
        cand  = last_owner;
        // Offsets 1..4 wrap modulo 4, so the last owner is checked last.
        for (int k = 1; k <= 4; k++) begin
            cand = 2'(int'(last_owner) + k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 multiplexer.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset_n - asynchronous active-low reset
//   bus     - request/grant bundle (slave side), see mux_select_arbiter_if
// Parameters:
//   MAX_HOLD - cycles a grant may be held before forced release (1..15)
module mux_select_arbiter
    import mux_select_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mux_select_arbiter_if.slave  bus
);

    localparam hold_cnt_t MaxHoldCnt = hold_cnt_t'(MAX_HOLD);

    arb_state_e            state_q, state_d;
    logic [NumSources-1:0] grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic [1:0]            addr_q, addr_d;
    logic                  timeout_q, timeout_d;
    hold_cnt_t             hold_cnt_q, hold_cnt_d;
    logic [1:0]            last_owner_q, last_owner_d;

    logic [NumSources-1:0] req_vec;
    logic [1:0]            pick_idx;
    logic                  pick_found;
    logic                  owner_req;
    logic                  hold_done;

    assign req_vec = {bus.req3, bus.req2, bus.req1, bus.req0};

    // While granted, the select lines always name the owner.
    assign owner_req = req_vec[addr_q];
    assign hold_done = (hold_cnt_q == MaxHoldCnt);

    rr_priority_picker u_picker (
        .req        (req_vec),
        .last_owner (last_owner_q),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StGranted;
                    grant_d    = onehot4(pick_idx);
                    valid_d    = 1'b1;
                    addr_d     = pick_idx;
                    hold_cnt_d = hold_cnt_t'(1);
                end else begin
                    // Select lines keep their last value so the mux output is stable.
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            StGranted: begin
                if (bus.owner_release || !owner_req || hold_done) begin
                    state_d      = StIdle;
                    grant_d      = '0;
                    valid_d      = 1'b0;
                    hold_cnt_d   = '0;
                    last_owner_d = addr_q;
                    // A voluntary end in the same cycle wins over the forced one.
                    timeout_d    = hold_done && !bus.owner_release && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            valid_q      <= 1'b0;
            addr_q       <= 2'd0;
            timeout_q    <= 1'b0;
            hold_cnt_q   <= '0;
            last_owner_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            timeout_q    <= timeout_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.address0    = addr_q[0];
    assign bus.address1    = addr_q[1];
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed self-checking bench for mux_select_arbiter (MAX_HOLD = 8).
module tb_mux_select_arbiter;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    mux_select_arbiter_if bus ();

    mux_select_arbiter #(
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Model of the downstream multiplexer with fixed data inputs.
    logic [7:0] mux_out;
    always_comb begin
        mux_out = 8'h00;
        case ({bus.address1, bus.address0})
            2'd0:    mux_out = 8'hA0;
            2'd1:    mux_out = 8'hA1;
            2'd2:    mux_out = 8'hA2;
            default: mux_out = 8'hA3;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are changed right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.req0 = r[0];
        bus.req1 = r[1];
        bus.req2 = r[2];
        bus.req3 = r[3];
    endtask

    task automatic check_grant(input string tag, input int owner);
        check({tag, "_grant"}, 32'(bus.grant), 32'(4'b0001 << owner));
        check({tag, "_addr"}, 32'({bus.address1, bus.address0}), 32'(owner));
        check({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_timeout);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_valid"}, 32'(bus.grant_valid), 32'd0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'(exp_timeout));
    endtask

    initial begin
        int order [5];
        n_checks          = 0;
        n_errors          = 0;
        reset_n           = 1'b0;
        bus.owner_release = 1'b0;
        set_req(4'b0000);
        order = '{0, 1, 2, 3, 0};

        // Reset state
        tick();
        tick();
        check_idle("reset", 1'b0);
        check("reset_addr", 32'({bus.address1, bus.address0}), 32'd0);

        // Round-robin through all four with release each grant
        reset_n = 1'b1;
        set_req(4'b1111);
        foreach (order[i]) begin
            tick();
            check_grant($sformatf("rr%0d", i), order[i]);
            bus.owner_release = 1'b1;
            tick();
            bus.owner_release = 1'b0;
            check_idle($sformatf("rr%0d_gap", i), 1'b0);
        end
        set_req(4'b0000);
        tick();
        check_idle("no_req", 1'b0);

        // Single-cycle req2 -> grant source 2, mux passes in2
        set_req(4'b0100);
        tick();
        check_grant("req2", 2);
        check("req2_mux", 32'(mux_out), 32'hA2);
        set_req(4'b0000);
        tick();
        check_idle("req2_drop", 1'b0);
        check("req2_addr_hold", 32'({bus.address1, bus.address0}), 32'd2);
        bus.owner_release = 1'b1;
        tick();
        bus.owner_release = 1'b0;
        check_idle("idle_release", 1'b0);
        check("idle_addr_hold", 32'({bus.address1, bus.address0}), 32'd2);

        // req1 held with no release -> forced release after 8 cycles
        set_req(4'b0010);
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("hold%0d_grant", i), 32'(bus.grant), 32'h2);
            check($sformatf("hold%0d_timeout", i), 32'(bus.timeout), 32'd0);
            if (i == 3) set_req(4'b0011);
            if (i == 6) set_req(4'b0010);
            if (i < 8) tick();
        end
        tick();
        check_idle("forced", 1'b1);
        tick();
        check_grant("regrant", 1);
        check("regrant_timeout", 32'(bus.timeout), 32'd0);

        // Release coincident with the final hold cycle -> no timeout
        for (int i = 0; i < 7; i++) tick();
        check("rel8_grant", 32'(bus.grant), 32'h2);
        bus.owner_release = 1'b1;
        tick();
        bus.owner_release = 1'b0;
        check_idle("rel8", 1'b0);

        // Request drop coincident with the final hold cycle -> no timeout
        tick();
        check_grant("drop8_start", 1);
        for (int i = 0; i < 7; i++) tick();
        check("drop8_grant", 32'(bus.grant), 32'h2);
        set_req(4'b0000);
        tick();
        check_idle("drop8", 1'b0);

        // Owner 3 aborted by reset; then source 0 has first priority
        set_req(4'b1000);
        tick();
        check_grant("own3", 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_rst", 1'b0);
        check("async_rst_addr", 32'({bus.address1, bus.address0}), 32'd0);
        tick();
        check_idle("rst_held", 1'b0);
        reset_n = 1'b1;
        set_req(4'b1001);
        tick();
        check_grant("post_rst", 0);

        // Owner 0 drops while req1 waits -> one idle cycle, then source 1
        set_req(4'b0010);
        tick();
        check_idle("own0_drop", 1'b0);
        tick();
        check_grant("own0_to1", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of cycles a grant is held before forced release (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 req0, req1, req2, req3  input  1 each  level requests from the four sources feeding the 4:1 multiplexer data inputs in0..in3.
REQ-005 release  input  1  single-cycle pulse from the current owner ending its grant.
REQ-006 address0  output  1  select LSB, wired directly to the multiplexer address0.
REQ-007 address1  output  1  select MSB, wired directly to the multiplexer address1.
REQ-008 grant  output  4  one-hot grant; bit i set means source i owns the multiplexer.
REQ-009 grant_valid  output  1  high while any grant is held.
REQ-010 timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANTED.
REQ-012 In IDLE with any reqi high, the block SHALL choose the next requester round-robin, starting at (last_owner+1) mod 4, and enter GRANTED on the next edge.
REQ-013 In IDLE with no request, the block SHALL stay in IDLE with grant=0000 and grant_valid=0.
REQ-014 grant, grant_valid, address0 and address1 SHALL be registered; latency from request sampled in IDLE to grant visible is one cycle.
REQ-015 On entering GRANTED for source i, {address1,address0} SHALL equal i, and grant SHALL have only bit i set.
REQ-016 In GRANTED, a hold counter (4 bits) SHALL start at 1 and increment each cycle the grant is held.
REQ-017 GRANTED SHALL return to IDLE on the next edge when release=1, when the owner's reqi=0, or when the hold counter equals MAX_HOLD.
REQ-018 On a forced release (counter equals MAX_HOLD, and neither release nor owner-req-drop that cycle), timeout SHALL pulse high for exactly one cycle, coincident with the return to IDLE.
REQ-019 If release or req-drop coincides with the counter reaching MAX_HOLD, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-020 Every release SHALL leave one IDLE cycle (grant_valid=0) before the next grant.
REQ-021 last_owner SHALL update to the owner on every return from GRANTED to IDLE.
REQ-022 In IDLE, address0/address1 SHALL hold their last granted value, so the multiplexer output is stable.
REQ-023 release asserted in IDLE SHALL be ignored.
REQ-024 Requests from non-owners in GRANTED SHALL be ignored until the next IDLE cycle.

Reset
REQ-025 reset_n=0 SHALL immediately force the state to IDLE, grant=0000, grant_valid=0, timeout=0, address0=0, address1=0, hold counter=0 and last_owner=3, so that source 0 has first priority.
REQ-026 A reset asserted mid-grant SHALL abort the grant without a timeout pulse.
REQ-027 After reset_n rises, the first arbitration SHALL occur at the first rising clk edge.

Structure
REQ-028 The state encoding (IDLE=0, GRANTED=1), the MAX_HOLD default, and the counter width SHALL live in a shared package.
REQ-029 The round-robin selection SHALL be a combinational sub-module named rr_priority_picker, with inputs being the 4-bit request and 2-bit last_owner and outputs being a 2-bit index and a found flag.

Verification
REQ-030 Reset, then req0..req3=1111 held with release pulsed each grant -> owners are granted in the order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-031 req2 alone, asserted one cycle -> next cycle {address1,address0}=10, grant=0100, grant_valid=1; the multiplexer output equals in2.
REQ-032 req1 held, MAX_HOLD=8, no release -> grant lasts 8 cycles, then timeout=1 for one cycle, then IDLE, then req1 is regranted.
REQ-033 release and counter=MAX_HOLD in the same cycle -> return to IDLE with timeout=0.
REQ-034 Owner 3 granted, reset_n pulsed low mid-grant -> all outputs are 0 asynchronously; after reset, req3 and req0 both high -> grant=0001.
REQ-035 Owner 0 drops req0 while req1=1 -> one IDLE cycle, then grant=0010 and {address1,address0}=01.
